// File: rtl/rx_pkg.sv
// rx_pkg: shared state encoding and configuration constants for the serial receive controller.
package rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RECV,
        STOP_CHK,
        CHECK,
        LOAD
    } rx_state_t;

    localparam int MIN_BIT_PERIOD     = 4;
    localparam int DEFAULT_BIT_PERIOD = 10;
    localparam int DEFAULT_DATA_SIZE  = 8;
    localparam int MIN_DATA_SIZE      = 5;
    localparam int MAX_DATA_SIZE      = 8;

endpackage

// File: rtl/rx_cfg_latch.sv
// rx_cfg_latch: clamps and holds the per-packet bit period and data size for the bit timer.
// Ports: clk/n_rst clock and async active-low reset; load captures cfg_* (after clamping);
//        bit_period/data_size are the held values, reset to the package defaults.
module rx_cfg_latch
    import rx_pkg::*;
#(
    parameter int BP_WIDTH       = 14,
    parameter int DS_WIDTH       = 4,
    parameter int MIN_BIT_PERIOD = rx_pkg::MIN_BIT_PERIOD
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                load,
    input  logic [BP_WIDTH-1:0] cfg_bit_period,
    input  logic [DS_WIDTH-1:0] cfg_data_size,
    output logic [BP_WIDTH-1:0] bit_period,
    output logic [DS_WIDTH-1:0] data_size
);

    logic [BP_WIDTH-1:0] bit_period_q, bit_period_d;
    logic [DS_WIDTH-1:0] data_size_q, data_size_d;

    // Too-short periods are raised to the minimum; out-of-range sizes fall back to a full byte.
    assign bit_period_d = (cfg_bit_period < BP_WIDTH'(MIN_BIT_PERIOD)) ? BP_WIDTH'(MIN_BIT_PERIOD) : cfg_bit_period;
    assign data_size_d  = (cfg_data_size >= DS_WIDTH'(MIN_DATA_SIZE) && cfg_data_size <= DS_WIDTH'(MAX_DATA_SIZE))
                          ? cfg_data_size : DS_WIDTH'(DEFAULT_DATA_SIZE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_period_q <= BP_WIDTH'(DEFAULT_BIT_PERIOD);
            data_size_q  <= DS_WIDTH'(DEFAULT_DATA_SIZE);
        end else if (load) begin
            bit_period_q <= bit_period_d;
            data_size_q  <= data_size_d;
        end
    end

    assign bit_period = bit_period_q;
    assign data_size  = data_size_q;

endmodule

// File: rtl/rx_ctrl_fsm.sv
// rx_ctrl_fsm: receive control FSM sequencing start, bit timing, stop check and buffer load.
// Ports: clk/n_rst clock and async active-low reset; rx_enable gates reception and aborts packets;
//        start_bit_detected/packet_done/stop_bit come from the receive datapath; data_read is the
//        host acknowledge; cfg_* is the requested timing. Outputs drive the bit timer
//        (enable_timer, bit_period, data_size), the stop-bit checker (sbc_clear, sbc_enable),
//        the rx buffer (load_buffer) and the host status (data_ready, framing_error,
//        overrun_error, busy). Every output comes from a register or the registered state.
module rx_ctrl_fsm
    import rx_pkg::*;
#(
    parameter int BP_WIDTH       = 14,
    parameter int DS_WIDTH       = 4,
    parameter int MIN_BIT_PERIOD = rx_pkg::MIN_BIT_PERIOD
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                rx_enable,
    input  logic                start_bit_detected,
    input  logic                packet_done,
    input  logic                stop_bit,
    input  logic                data_read,
    input  logic [BP_WIDTH-1:0] cfg_bit_period,
    input  logic [DS_WIDTH-1:0] cfg_data_size,
    output logic                enable_timer,
    output logic [BP_WIDTH-1:0] bit_period,
    output logic [DS_WIDTH-1:0] data_size,
    output logic                sbc_clear,
    output logic                sbc_enable,
    output logic                load_buffer,
    output logic                data_ready,
    output logic                framing_error,
    output logic                overrun_error,
    output logic                busy
);

    rx_state_t state_q, state_d;
    logic      data_ready_q, data_ready_d;
    logic      framing_error_q, framing_error_d;
    logic      overrun_error_q, overrun_error_d;
    logic      cfg_load;

    rx_cfg_latch #(
        .BP_WIDTH      (BP_WIDTH),
        .DS_WIDTH      (DS_WIDTH),
        .MIN_BIT_PERIOD(MIN_BIT_PERIOD)
    ) u_cfg (
        .clk           (clk),
        .n_rst         (n_rst),
        .load          (cfg_load),
        .cfg_bit_period(cfg_bit_period),
        .cfg_data_size (cfg_data_size),
        .bit_period    (bit_period),
        .data_size     (data_size)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            data_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            data_ready_q    <= data_ready_d;
            framing_error_q <= framing_error_d;
            overrun_error_q <= overrun_error_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        data_ready_d    = data_read ? 1'b0 : data_ready_q;
        overrun_error_d = data_read ? 1'b0 : overrun_error_q;
        framing_error_d = framing_error_q;
        cfg_load        = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_load = rx_enable && start_bit_detected;
                state_d  = cfg_load ? START : IDLE;
            end
            START: begin
                state_d         = rx_enable ? RECV : IDLE;
                framing_error_d = rx_enable ? 1'b0 : framing_error_q;
            end
            RECV:     state_d = !rx_enable ? IDLE : (packet_done ? STOP_CHK : RECV);
            STOP_CHK: state_d = rx_enable ? CHECK : IDLE;
            CHECK: begin
                state_d         = (rx_enable && stop_bit) ? LOAD : IDLE;
                framing_error_d = (rx_enable && !stop_bit) ? 1'b1 : framing_error_q;
            end
            LOAD: begin
                state_d      = IDLE;
                data_ready_d = 1'b1;
                // A read landing on the load cycle consumes the old word, so no overrun.
                overrun_error_d = overrun_error_d | (data_ready_q & ~data_read);
            end
            default: state_d = IDLE;
        endcase
    end

    assign enable_timer  = (state_q == RECV);
    assign sbc_clear     = (state_q == START);
    assign sbc_enable    = (state_q == STOP_CHK);
    assign load_buffer   = (state_q == LOAD);
    assign busy          = (state_q != IDLE);
    assign data_ready    = data_ready_q;
    assign framing_error = framing_error_q;
    assign overrun_error = overrun_error_q;

endmodule

// File: doc/rx_ctrl_fsm.md
Name: rx_ctrl_fsm

Overview:
- Receive control unit for the serial receiver.
- Detects the start of a packet and latches the per-packet configuration into the bit timer.
- Gates the timer's enable, then sequences stop-bit check, framing validation and buffer load.
- Owns the data_ready/data_read handshake to the host side and flags framing and overrun errors.

Parameters:
BP_WIDTH, 14, width of bit_period configuration and timer input
DS_WIDTH, 4, width of data_size configuration and timer input
MIN_BIT_PERIOD, 4, smallest bit period passed to the timer; smaller requests are clamped up

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  asynchronous active-low reset
rx_enable  input  1  receiver enable; low ignores start bits and aborts an in-flight packet
start_bit_detected  input  1  one-cycle pulse from start-bit edge detector
packet_done  input  1  one-cycle pulse from bit timer when last bit period completes
stop_bit  input  1  sampled stop bit from the shift register
data_read  input  1  host acknowledge, clears data_ready
cfg_bit_period  input  BP_WIDTH  requested clocks per bit
cfg_data_size  input  DS_WIDTH  requested data bits (5..8)
enable_timer  output  1  enables the bit timer
bit_period  output  BP_WIDTH  latched bit period driven to the timer
data_size  output  DS_WIDTH  latched data size driven to the timer
sbc_clear  output  1  clears the stop-bit checker
sbc_enable  output  1  stop-bit checker sample strobe
load_buffer  output  1  one-cycle load of the shifted data into the rx buffer
data_ready  output  1  buffer holds unread data
framing_error  output  1  last packet's stop bit was 0
overrun_error  output  1  a new packet was loaded while data_ready was still set
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: all 1-bit outputs 0, state IDLE, bit_period = 14'd10, data_size = 4'd8.
- States: IDLE, START, RECV, STOP_CHK, CHECK, LOAD; all outputs registered or decoded from the registered state; no combinational input-to-output path.
- IDLE:
  - When rx_enable=1 and start_bit_detected=1, latch the configuration and go to START.
  - start_bit_detected while rx_enable=0 is ignored.
- Configuration latch rules:
  - bit_period = max(cfg_bit_period, MIN_BIT_PERIOD).
  - data_size = cfg_data_size if in 5..8, else 8.
  - Latched values are held constant until the next START; mid-packet cfg changes have no effect.
- START: one cycle; sbc_clear=1, framing_error cleared; then RECV.
- RECV:
  - enable_timer=1 throughout.
  - packet_done=1 moves to STOP_CHK; enable_timer drops in the same cycle the state changes.
- STOP_CHK: one cycle; sbc_enable=1, enable_timer=0; then CHECK.
- CHECK:
  - If stop_bit=0: framing_error<=1 and return to IDLE with no load.
  - Otherwise go to LOAD.
- LOAD: one cycle; load_buffer=1; then IDLE.
  - data_ready<=1.
  - If data_ready was already 1 and data_read=0 this cycle, overrun_error<=1.
- Handshake:
  - data_read=1 clears data_ready and overrun_error on the next edge.
  - data_read coincident with LOAD: data_ready stays 1 and overrun is not flagged.
- Abort: rx_enable=0 in START/RECV/STOP_CHK/CHECK returns to IDLE next cycle.
  - enable_timer=0, no load_buffer.
  - framing_error, data_ready and overrun_error keep their values.
- start_bit_detected outside IDLE is ignored.
- packet_done outside RECV is ignored.
- Latency: start_bit_detected to enable_timer=1 is 2 cycles; packet_done to load_buffer is 3 cycles.
- Async reset mid-packet returns everything to reset values immediately.

Decomposition:
- Package rx_pkg holds:
  - the state enum (rx_state_t, 3-bit encoding);
  - MIN_BIT_PERIOD, DEFAULT_BIT_PERIOD=10, DEFAULT_DATA_SIZE=8, MIN_DATA_SIZE=5, MAX_DATA_SIZE=8.
- One natural sub-module, rx_cfg_latch: performs clamping and holds bit_period/data_size under a single load strobe from the FSM.
- FSM, handshake and error flags stay in rx_ctrl_fsm.

Test Plan:
- Reset then idle → all flags 0, bit_period=10, data_size=8, busy=0.
- Config cfg_bit_period=10, cfg_data_size=8; start pulse; packet_done 100 cycles later with stop_bit=1 → enable_timer high from cycle 2 to the packet_done cycle; load_buffer exactly 3 cycles after packet_done; data_ready=1, framing_error=0.
- Same packet with stop_bit=0 → framing_error=1, no load_buffer, data_ready unchanged; framing_error clears on the next START.
- Two good packets with no data_read → overrun_error=1 on the second LOAD. Repeat with data_read asserted in the LOAD cycle → no overrun, data_ready stays 1.
- cfg_bit_period=2, cfg_data_size=12 → latched bit_period=4, data_size=8. Changing cfg during RECV leaves the outputs unchanged.
- rx_enable dropped mid-RECV → IDLE next cycle, enable_timer=0, no load. A start pulse while rx_enable=0 leaves busy=0.
